uart_receiver: RTL and testbench

Asynchronous serial receiver: 8N1 framing, 16x oversampling, mid-bit sampling. It is the downstream stage of the board's UART transmitter. It recovers bytes from a serial line (the transmitter's `txd` in loopback, or the board RXD pin) and presents each one with a one-cycle strobe. A framing-error strobe flags bad stop bits.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_receiver_clkenb.sv | 38 +++
 rtl/uart_receiver.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// oversample divider calculation used by both the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_DBITS = 8;

    // Clocks per oversample tick; integer division, caller checks for >= 1.
    function automatic int uart_div(input int clkfreq, input int baud, input int oversample);
        return clkfreq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_receiver_clkenb.sv
// Oversample tick generator: registered one-clock enable every DIVAMT clocks.
// A clear restarts the count so the tick phase follows the start edge.
module clkenb #(
    parameter int DIVAMT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic enb
);

    localparam int            CW   = (DIVAMT > 1) ? $clog2(DIVAMT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVAMT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          wrap_s;

    // Terminal count of the divider
    always_comb begin
        wrap_s = (cnt_r == LAST);
    end

    // Divider counter and registered tick output
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= '0;
            enb   <= 1'b0;
        end else if (wrap_s) begin
            cnt_r <= '0;
            enb   <= 1'b1;
        end else begin
            cnt_r <= cnt_r + ONE;
            enb   <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with OVERSAMPLE-times oversampling and mid-bit sampling.
// Emits a one-clock rdy with the byte on data, or a one-clock ferr when the
// stop bit samples low. A low line only restarts reception after a new
// high-to-low edge.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKFREQ    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       rdy,
    output logic       ferr
);

    localparam int DIV = uart_div(CLKFREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(UART_DBITS);

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(UART_DBITS - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);

    if (DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_param_check
        $error("uart_receiver: invalid CLKFREQ/BAUD/OVERSAMPLE combination");
    end

    rx_state_t                 state_r;
    rx_state_t                 next_state_s;
    logic                      rxd_meta_r;
    logic                      rxd_sync_r;
    logic                      rxd_prev_r;
    logic [SW-1:0]             scnt_r;
    logic [BW-1:0]             bcnt_r;
    logic [UART_DBITS-1:0]     shreg_r;
    logic                      tick_s;
    logic                      fall_s;
    logic                      scnt_half_s;
    logic                      scnt_last_s;
    logic                      scnt_clr_s;
    logic                      scnt_inc_s;
    logic                      bcnt_clr_s;
    logic                      bcnt_inc_s;
    logic                      shift_s;
    logic                      tick_clr_s;
    logic                      rdy_s;
    logic                      ferr_s;

    clkenb #(
        .DIVAMT (DIV)
    ) u_clkenb (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr_s),
        .enb (tick_s)
    );

    // Two-stage synchronizer plus previous-value stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Edge and sample-count decodes
    always_comb begin
        fall_s      = rxd_prev_r & ~rxd_sync_r;
        scnt_half_s = (scnt_r == S_HALF);
        scnt_last_s = (scnt_r == S_LAST);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    next_state_s = START;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: begin
                if (tick_s && scnt_half_s) begin
                    next_state_s = rxd_sync_r ? IDLE : DATA;
                end else begin
                    next_state_s = START;
                end
            end
            DATA: begin
                if (tick_s && scnt_last_s && (bcnt_r == B_LAST)) begin
                    next_state_s = STOP;
                end else begin
                    next_state_s = DATA;
                end
            end
            STOP: begin
                if (tick_s && scnt_last_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = STOP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // FSM output decode: counter control, shift enable and result strobes
    always_comb begin
        scnt_clr_s = 1'b0;
        scnt_inc_s = 1'b0;
        bcnt_clr_s = 1'b0;
        bcnt_inc_s = 1'b0;
        shift_s    = 1'b0;
        tick_clr_s = 1'b0;
        rdy_s      = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_s) begin
                    scnt_clr_s = 1'b1;
                    bcnt_clr_s = 1'b1;
                    tick_clr_s = 1'b1;
                end else begin
                    tick_clr_s = 1'b0;
                end
            end
            START: begin
                if (tick_s && scnt_half_s) begin
                    scnt_clr_s = 1'b1;
                    bcnt_clr_s = 1'b1;
                end else if (tick_s) begin
                    scnt_inc_s = 1'b1;
                end else begin
                    scnt_inc_s = 1'b0;
                end
            end
            DATA: begin
                if (tick_s && scnt_last_s) begin
                    shift_s    = 1'b1;
                    scnt_clr_s = 1'b1;
                    if (bcnt_r == B_LAST) begin
                        bcnt_clr_s = 1'b1;
                    end else begin
                        bcnt_inc_s = 1'b1;
                    end
                end else if (tick_s) begin
                    scnt_inc_s = 1'b1;
                end else begin
                    scnt_inc_s = 1'b0;
                end
            end
            STOP: begin
                if (tick_s && scnt_last_s) begin
                    scnt_clr_s = 1'b1;
                    rdy_s      = rxd_sync_r;
                    ferr_s     = ~rxd_sync_r;
                end else if (tick_s) begin
                    scnt_inc_s = 1'b1;
                end else begin
                    scnt_inc_s = 1'b0;
                end
            end
            default: begin
                scnt_clr_s = 1'b1;
                bcnt_clr_s = 1'b1;
            end
        endcase
    end

    // Sample counter, bit counter and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_r  <= '0;
            bcnt_r  <= '0;
            shreg_r <= '0;
        end else begin
            if (scnt_clr_s) begin
                scnt_r <= '0;
            end else if (scnt_inc_s) begin
                scnt_r <= scnt_r + S_ONE;
            end
            if (bcnt_clr_s) begin
                bcnt_r <= '0;
            end else if (bcnt_inc_s) begin
                bcnt_r <= bcnt_r + B_ONE;
            end
            if (shift_s) begin
                shreg_r <= {rxd_sync_r, shreg_r[UART_DBITS-1:1]};
            end
        end
    end

    // Registered result outputs; data only changes on a good stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= 8'h00;
            rdy  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            rdy  <= rdy_s;
            ferr <= ferr_s;
            if (rdy_s) begin
                data <= shreg_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames,
// compared against an event-level model of what each frame must produce.
module tb_uart_receiver;

    localparam int CLKFREQ    = 100_000_000;
    localparam int BAUD       = 625_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = 160;
    localparam int LAT_LO     = 1518;
    localparam int LAT_HI     = 1530;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       rdy;
    logic       ferr;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    int         bad_pulse = 0;
    logic       rdy_d = 1'b0;
    logic       ferr_d = 1'b0;
    logic [7:0] exp_data = 8'h00;

    // Observed events: {1'b0, byte} for rdy, 9'h100 for ferr
    logic [8:0] ev_q[$];
    int         ev_cyc_q[$];
    logic [8:0] exp_q[$];

    uart_receiver #(
        .CLKFREQ    (CLKFREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .data (data),
        .rdy  (rdy),
        .ferr (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes away from the active edge and flag malformed pulses
    always @(negedge clk) begin
        if (rdy === 1'b1) begin
            ev_q.push_back({1'b0, data});
            ev_cyc_q.push_back(cyc);
        end
        if (ferr === 1'b1) begin
            ev_q.push_back(9'h100);
            ev_cyc_q.push_back(cyc);
        end
        if ((rdy === 1'b1 && ferr === 1'b1) || (rdy === 1'b1 && rdy_d) ||
            (ferr === 1'b1 && ferr_d))
            bad_pulse++;
        rdy_d  = (rdy === 1'b1);
        ferr_d = (ferr === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert ((obs >= lo && obs <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic check_events(input string tag);
        check({tag, "_count"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
            check($sformatf("%s_ev%0d", tag, i), {23'd0, ev_q[i]}, {23'd0, exp_q[i]});
        ev_q.delete();
        ev_cyc_q.delete();
        exp_q.delete();
    endtask

    // Drive one 8N1 frame, LSB first; optionally pulse rst mid-way through frame bit rst_bit
    task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop, input int rst_bit);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = fr[i];
            if (i == 0) last_start_cyc = cyc;
            if (i == rst_bit) begin
                repeat (bclk / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (bclk - bclk / 2 - 1) @(negedge clk);
            end else begin
                repeat (bclk) @(negedge clk);
            end
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int start0;
        int start1;

        // Reset state
        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_rdy", {31'd0, rdy}, 32'h0);
        check("reset_ferr", {31'd0, ferr}, 32'h0);
        rst = 1'b0;
        idle(20);

        // Single frame 8'hAE with latency window
        send_frame(8'hAE, BIT_CLKS, 1'b1, -1);
        start0 = last_start_cyc;
        idle(300);
        exp_q.push_back({1'b0, 8'hAE});
        exp_data = 8'hAE;
        check_range("ae_latency", (ev_cyc_q.size() > 0) ? ev_cyc_q[0] - start0 : -1, LAT_LO, LAT_HI);
        check_events("ae");
        check("ae_data", {24'd0, data}, {24'd0, exp_data});

        // Back-to-back 8'h2A then 8'hAE
        send_frame(8'h2A, BIT_CLKS, 1'b1, -1);
        start0 = last_start_cyc;
        send_frame(8'hAE, BIT_CLKS, 1'b1, -1);
        start1 = last_start_cyc;
        idle(300);
        check("b2b_start_gap", start1 - start0, 10 * BIT_CLKS);
        check_range("b2b_spacing", (ev_cyc_q.size() > 1) ? ev_cyc_q[1] - ev_cyc_q[0] : -1, 1595, 1605);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b0, 8'hAE});
        exp_data = 8'hAE;
        check_events("b2b");
        check("b2b_data", {24'd0, data}, {24'd0, exp_data});

        // 40-clock glitch on an idle line: no strobe
        rxd = 1'b0;
        repeat (40) @(negedge clk);
        idle(400);
        check_events("glitch");
        check("glitch_data", {24'd0, data}, {24'd0, exp_data});

        // Bad stop bit for 8'h55, then line held low
        send_frame(8'h55, BIT_CLKS, 1'b0, -1);
        rxd = 1'b0;
        repeat (3000) @(negedge clk);
        exp_q.push_back(9'h100);
        check_events("ferr");
        check("ferr_data_held", {24'd0, data}, {24'd0, exp_data});
        idle(400);
        check_events("ferr_release");

        // Reset during data bit 4 of 8'hFF, then 8'h01
        send_frame(8'hFF, BIT_CLKS, 1'b1, 5);
        idle(400);
        exp_data = 8'h00;
        check_events("rst_mid");
        check("rst_mid_data", {24'd0, data}, {24'd0, exp_data});
        send_frame(8'h01, BIT_CLKS, 1'b1, -1);
        idle(300);
        exp_q.push_back({1'b0, 8'h01});
        exp_data = 8'h01;
        check_events("after_rst");
        check("after_rst_data", {24'd0, data}, {24'd0, exp_data});

        // Baud tolerance: -3% and +3% bit periods
        send_frame(8'hC3, 155, 1'b1, -1);
        idle(300);
        exp_q.push_back({1'b0, 8'hC3});
        check_events("fast");
        check("fast_data", {24'd0, data}, 32'hC3);
        send_frame(8'hC3, 165, 1'b1, -1);
        idle(300);
        exp_q.push_back({1'b0, 8'hC3});
        exp_data = 8'hC3;
        check_events("slow");
        check("slow_data", {24'd0, data}, {24'd0, exp_data});

        // Random frames: random byte, bit period, stop bit and idle gap
        for (int n = 0; n < 10; n++) begin
            logic [7:0] b;
            int         bp;
            logic       stp;
            int         gap;
            b   = 8'($urandom);
            bp  = $urandom_range(165, 155);
            stp = ($urandom_range(3, 0) != 0);
            gap = stp ? $urandom_range(200, 0) : $urandom_range(300, 20);
            send_frame(b, bp, stp, -1);
            if (stp) begin
                exp_q.push_back({1'b0, b});
                exp_data = b;
            end else begin
                exp_q.push_back(9'h100);
            end
            idle(gap);
        end
        idle(400);
        check_events("rand");
        check("rand_data", {24'd0, data}, {24'd0, exp_data});

        check("pulse_shape", bad_pulse, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
